// File: rtl/shift_pkg.sv
// Shared types for the sequential shift unit.
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'b00,
    SHIFT_SRL  = 2'b01,
    SHIFT_SRA  = 2'b10,
    SHIFT_RSVD = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } shift_state_t;

endpackage

// File: rtl/shift_multicycle_stage.sv
// One power-of-two stage of the log-decomposed shifter: shifts data by
// 2^stage according to op, or passes it through when disabled or op=RSVD.
module shift_stage
  import shift_pkg::*;
#(
  parameter  int N = 32,
  localparam int S = $clog2(N)
) (
  input  logic [N-1:0] data,
  input  logic [S-1:0] stage,
  input  logic         enable,
  input  shift_op_t    op,
  output logic [N-1:0] shifted
);

  logic [S-1:0] w_amt;

  assign w_amt = S'(1) << stage;

  // Select the shift flavour; SRA replicates the current MSB, which stays the
  // original sign because every earlier stage also preserved it.
  always_comb begin
    shifted = data;
    if (enable) begin
      unique case (op)
        SHIFT_SLL:  shifted = data << w_amt;
        SHIFT_SRL:  shifted = data >> w_amt;
        SHIFT_SRA:  shifted = $unsigned($signed(data) >>> w_amt);
        default:    shifted = data;
      endcase
    end
  end

endmodule

// File: rtl/shift_multicycle.sv
// Area-reduced shift unit: accepts one request, applies one power-of-two
// stage per clock from the largest down to 1, then holds the result until
// the consumer takes it.
module shift_multicycle
  import shift_pkg::*;
#(
  parameter  int N = 32,
  localparam int S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [S-1:0] in_shamt,
  input  shift_op_t    in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
);

  shift_state_t r_state;
  shift_state_t w_state_nxt;
  logic [N-1:0] r_acc;
  logic [S-1:0] r_shamt;
  shift_op_t    r_op;
  logic [S-1:0] r_cnt;
  logic [N-1:0] w_stage_out;
  logic         w_stage_en;
  logic         w_accept;

  assign w_stage_en = r_shamt[r_cnt];

  shift_stage #(.N(N)) u_stage (
    .data    (r_acc),
    .stage   (r_cnt),
    .enable  (w_stage_en),
    .op      (r_op),
    .shifted (w_stage_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs; all outputs depend on state only.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture, per-stage accumulator update and stage countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_shamt <= '0;
      r_op    <= SHIFT_SLL;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc   <= in_data;
            r_shamt <= in_shamt;
            r_op    <= in_op;
            r_cnt   <= S'(S - 1);
          end
        end
        S_SHIFT: begin
          r_acc <= w_stage_out;
          if (r_cnt != '0) r_cnt <= r_cnt - S'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data = r_acc;

endmodule

// File: tb/tb_shift_multicycle.sv
// Directed and randomised bench for shift_multicycle (N=32).
module tb_shift_multicycle;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  shift_op_t   in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  shift_multicycle #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sh,
                                            input logic [1:0] op);
    case (op)
      2'b00:   return d << sh;
      2'b01:   return d >> sh;
      2'b10:   return $unsigned($signed(d) >>> sh);
      default: return d;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full request/response with optional result stall; inputs are scrambled
  // after the accept edge and a stray request is offered during the stall.
  task automatic run_txn(input string tag, input logic [31:0] d, input logic [4:0] sh,
                         input logic [1:0] op, input logic [31:0] exp, input int stall);
    int w;
    int cyc;
    w        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_op    = shift_op_t'(op);
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    check({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    in_data  = ~d;
    in_shamt = ~sh;
    in_op    = shift_op_t'(op ^ 2'b01);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_not_ready"}, in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 5);
    for (int i = 0; i < stall; i++) begin
      check({tag, "_stall_data"}, out_data, exp);
      check({tag, "_stall_ready"}, in_ready, 0);
      in_valid = 1'b1;
      in_data  = 32'h1234_5678;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, exp);
    step();
    out_ready = 1'b0;
    check({tag, "_post_valid"}, out_valid, 0);
    check({tag, "_post_ready"}, in_ready, 1);
    check({tag, "_post_busy"}, busy, 0);
  endtask

  initial begin
    logic [31:0] d;
    logic [4:0]  sh;
    logic [1:0]  op;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = SHIFT_SLL;
    out_ready = 1'b0;
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    run_txn("sra31",  32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 0);
    run_txn("sll5",   32'h0000_0001, 5'd5,  2'b00, 32'h0000_0020, 0);
    run_txn("srl4",   32'hF000_0000, 5'd4,  2'b01, 32'h0F00_0000, 0);
    run_txn("sra4",   32'h7000_0000, 5'd4,  2'b10, 32'h0700_0000, 0);
    run_txn("sra0",   32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF, 0);
    run_txn("rsvd7",  32'hDEAD_BEEF, 5'd7,  2'b11, 32'hDEAD_BEEF, 0);
    run_txn("sll31",  32'h0000_0003, 5'd31, 2'b00, 32'h8000_0000, 0);
    run_txn("srl31",  32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 0);
    run_txn("stall3", 32'hC000_0010, 5'd3,  2'b10, 32'hF800_0002, 3);

    // Reset two cycles after accept drops the in-flight request.
    in_valid = 1'b1;
    in_data  = 32'h0000_00FF;
    in_shamt = 5'd4;
    in_op    = SHIFT_SLL;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    run_txn("after_rst", 32'h0000_00FF, 5'd4, 2'b00, 32'h0000_0FF0, 1);

    for (int n = 0; n < 1000; n++) begin
      d  = $urandom;
      sh = 5'($urandom_range(0, 31));
      op = 2'($urandom_range(0, 3));
      run_txn("rand", d, sh, op, ref_shift(d, sh, op), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
